uart_rx_deser: RTL and testbench
================================

# uart_rx_deser

UART receive deserializer sitting directly downstream of the receive-enable generator. It takes the raw `rx` line and the generator's `en` window, detects and validates start bits, samples each bit at mid-bit, and assembles LSB-first bytes. Completed bytes are held in a one-entry output buffer with a valid/ready handshake toward the byte consumer. The block also reports framing errors and overruns.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; must be even and ≥ 4.
- `DATA_BITS`, 8: data bits per frame, range 5–8.
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `rx`  input  1  asynchronous serial line; idle high.
- `en`  input  1  receive-enable window from the enable generator. When low in IDLE, start bits are not accepted. It is ignored once a frame has started.
- `out_data`  output  DATA_BITS  received byte, right-aligned.
- `out_valid`  output  1  buffer holds an unconsumed byte.
- `out_ready`  input  1  consumer accepts `out_data` when `out_valid && out_ready`.
- `frame_err`  output  1  one-cycle pulse when the stop bit is sampled 0.
- `overrun`  output  1  one-cycle pulse when a completed byte is dropped.
- `parity_err`  output  1  one-cycle pulse on a parity mismatch. Constant 0 when parity is compiled out.

## Operation
- **Input synchronizer:** `rx` passes through a 2-FF synchronizer; the result is `rx_s`. A third register, `rx_d`, provides edge detection. The synchronizers reset to 1.
- **Start detection:** a start is detected when `rx_d==1 && rx_s==0 && en==1` in IDLE.
- **States:**
  - IDLE → START on start detection; the bit counter and clock counter are cleared.
  - START: at clock count CLKS_PER_BIT/2-1 (mid start bit):
    - if `rx_s==0`, go to DATA and clear the clock counter;
    - otherwise treat it as a glitch and return to IDLE with no output.
  - DATA: sample `rx_s` whenever the clock count reaches CLKS_PER_BIT-1.
    - Shift right into the shift register (LSB first) and increment the bit index.
    - After DATA_BITS samples, go to PARITY if enabled, else to STOP.
  - PARITY: sample one bit at the same point and compare it with the even parity of the shifted data. Then go to STOP.
  - STOP: sample at the same point.
    - `rx_s==1`: frame good; go to IDLE.
    - `rx_s==0`: pulse `frame_err`, discard the byte, go to IDLE. The falling-edge rule prevents a retrigger until the line has returned high.
- **Byte commit** (good stop bit, and no parity error when parity is enabled):
  - `out_valid==0`: load `out_data`; set `out_valid`.
  - `out_valid==1 && out_ready==1` in the same cycle: load the new byte; `out_valid` stays 1; no overrun.
  - `out_valid==1 && out_ready==0`: keep the old byte, drop the new one, pulse `overrun`.
- **Parity failure:** on a parity failure, pulse `parity_err` and drop the byte. `frame_err` takes priority if both errors occur; only `frame_err` pulses.
- **Handshake:** `out_valid` clears on `out_valid && out_ready` when there is no simultaneous commit. `out_data` is stable while `out_valid` is high.
- **Counters:**
  - The clock counter is $clog2(CLKS_PER_BIT) bits wide and wraps to 0 at CLKS_PER_BIT-1.
  - The bit index is $clog2(DATA_BITS+1) bits wide.

## Timing
- **Reset** (`rst` high, any state including mid-frame), on the next edge:
  - state returns to IDLE and all counters clear;
  - `out_data=0`, `out_valid=0`, `frame_err=0`, `overrun=0`, `parity_err=0`;
  - the synchronizers are set to 1. The partially received frame is lost.
- **Start latency:** 3 cycles from a falling edge on `rx` to START entry (2 synchronizer stages plus 1 edge register).
- **Output latency:** `out_valid` rises 1 cycle after the stop-bit sample edge.
- **Total latency:** the start-bit falling edge to `out_valid` is (1+DATA_BITS+P)·CLKS_PER_BIT + CLKS_PER_BIT/2 + 4 cycles, where P=1 if parity is enabled, else 0.
- **Error pulses:** `frame_err`, `parity_err` and `overrun` are registered, exactly one cycle wide, and aligned with the cycle in which `out_valid` would have risen.

## Configuration
- `UART_RX_PARITY_EN`:
  - **Defined:** the PARITY state exists, one even-parity bit between the data bits and the stop bit is checked, and `parity_err` is live.
  - **Undefined:** the frame is start + DATA_BITS + stop, STOP follows DATA directly, and `parity_err` is tied to 0.
- The port list is identical in both builds.

## Structure
- **Shared package `uart_pkg`:**
  - the state enum `uart_rx_state_t`: IDLE, START, DATA, PARITY, STOP;
  - the default constants `UART_CLKS_PER_BIT_DEF=16` and `UART_DATA_BITS_DEF=8`.
- **Sub-module `uart_rx_sync`:** the natural sub-module. It contains the 2-FF synchronizer plus the edge register, and outputs `rx_s` and `fall`.

## Test plan
All scenarios use CLKS_PER_BIT=16 and DATA_BITS=8; `out_ready=1` unless stated.
- **Good frame:** send 0xA5 with `en=1` → `out_valid` rises 8·16+16+8+4=156 cycles after the start edge, `out_data=0xA5`, no error pulses.
- **Glitch rejection:** hold `rx` low for 3 cycles, then high → no START→DATA transition, `out_valid` stays 0. Also: a valid start with `en=0` → no reception.
- **Framing error:** send 0x3C with the stop bit forced 0 → one `frame_err` pulse, `out_valid` stays 0. The next frame, 0x11, after the line returns high is received correctly.
- **Overrun:** with `out_ready=0`, send 0x01 then 0x02 → `out_data=0x01`, one `overrun` pulse at the second commit. Raising `out_ready` consumes 0x01 and `out_valid` drops.
- **Reset mid-frame:** assert `rst` for 1 cycle during DATA bit 4 of 0xFF → all outputs are 0 on the next cycle. A following 0x5A is received intact.
- **Parity** (`UART_RX_PARITY_EN` defined):
  - 0x07 with parity bit 1 → accepted.
  - 0x07 with parity bit 0 → one `parity_err` pulse, no `out_valid`.

Source files
------------

// File: rtl/uart_pkg.sv
// UART shared types and defaults.
// Latency: none (declarations only). Backpressure: not applicable.
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_t;

    localparam int UART_CLKS_PER_BIT_DEF = 16;
    localparam int UART_DATA_BITS_DEF    = 8;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw rx line plus an edge register for falling-edge detect.
// Latency: 2 cycles to o_rx_s, o_fall asserted on the cycle o_rx_s first reads low. Backpressure: none.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall
);
    logic r_meta;
    logic r_rx_s;
    logic r_rx_d;

    // Idle-high reset values keep a held-low line from looking like a fresh start edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_rx_s <= 1'b1;
            r_rx_d <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_rx_s <= r_meta;
            r_rx_d <= r_rx_s;
        end
    end

    assign o_rx_s = r_rx_s;
    assign o_fall = r_rx_d & ~r_rx_s;
endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: start validation, mid-bit sampling, LSB-first assembly; UART_RX_PARITY_EN adds even parity.
// Latency: start edge to out_valid = (1+DATA_BITS+P)*CLKS_PER_BIT + CLKS_PER_BIT/2 + 4. Backpressure: 1-entry buffer, overflow drops new byte and pulses overrun.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = UART_DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 en,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    logic w_rx_s;
    logic w_fall;
    logic w_cnt_last;
    logic w_cnt_mid;
    logic w_bit_last;
    logic w_good;

    uart_rx_state_t       r_state;
    logic [CW-1:0]        r_clk_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_done;
    logic                 r_stop_ok;
    logic [DATA_BITS-1:0] r_out_data;
    logic                 r_out_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    uart_rx_sync u_sync (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_rx   (rx),
        .o_rx_s (w_rx_s),
        .o_fall (w_fall)
    );

    assign w_cnt_last = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_cnt_mid  = (r_clk_cnt == CW'(CLKS_PER_BIT / 2 - 1));
    assign w_bit_last = (r_bit_idx == BW'(DATA_BITS - 1));

`ifdef UART_RX_PARITY_EN
    logic r_par_ok;
    logic r_parity_err;

    assign w_good     = r_stop_ok & r_par_ok;
    assign parity_err = r_parity_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_ok     <= 1'b1;
            r_parity_err <= 1'b0;
        end else begin
            if (r_state == PARITY && w_cnt_last)
                r_par_ok <= (w_rx_s == ^r_shift);
            // A bad stop bit masks the parity report.
            r_parity_err <= r_done & r_stop_ok & ~r_par_ok;
        end
    end
`else
    assign w_good     = r_stop_ok;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_done      <= 1'b0;
            r_stop_ok   <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    if (w_fall && en)
                        r_state <= START;
                end
                START: begin
                    if (w_cnt_mid) begin
                        r_clk_cnt <= '0;
                        r_state   <= w_rx_s ? IDLE : DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    r_clk_cnt <= w_cnt_last ? '0 : r_clk_cnt + CW'(1);
                    if (w_cnt_last) begin
                        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + BW'(1);
                        if (w_bit_last) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end
                end
                PARITY: begin
                    r_clk_cnt <= w_cnt_last ? '0 : r_clk_cnt + CW'(1);
                    if (w_cnt_last)
                        r_state <= STOP;
                end
                STOP: begin
                    r_clk_cnt <= w_cnt_last ? '0 : r_clk_cnt + CW'(1);
                    if (w_cnt_last) begin
                        r_done    <= 1'b1;
                        r_stop_ok <= w_rx_s;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Commit one cycle after the stop sample so pulses line up with out_valid.
            r_frame_err <= r_done & ~r_stop_ok;
            r_overrun   <= 1'b0;
            if (r_done && w_good) begin
                if (!r_out_valid || out_ready) begin
                    r_out_data  <= r_shift;
                    r_out_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
endmodule

// File: tb/tb_uart_rx_deser.sv
// Scoreboard bench for uart_rx_deser: directed frames, expected bytes queued at stimulus, popped on handshake.
module tb_uart_rx_deser;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int LAT = (1 + 8 + P) * CPB + CPB / 2 + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       en = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int t_start = 0;
    int n_rise = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    int n_perr = 0;
    logic prev_v = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_deser #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .en         (en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected bytes on each accepted handshake, tallies pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_v) begin
                rise_cyc = cyc;
                n_rise++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", int'(out_data), 999);
                end else begin
                    chk("byte", int'(out_data), int'(exp_q.pop_front()));
                end
            end
            if (frame_err)  n_ferr++;
            if (overrun)    n_ovr++;
            if (parity_err) n_perr++;
        end
        prev_v = out_valid;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        idle(4);
        t_start = cyc;
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_out((^d) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored without parity");
`endif
        bit_out(stop_b);
        rx = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        int r0, f0, o0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_parity_err", int'(parity_err), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(10);

        // Good frame and latency
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(4);
        chk("latency", rise_cyc - t_start, LAT);
        drain("drain_a5");

        // Short glitch, then a real frame while en is low
        r0 = n_rise;
        idle(4);
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(40);
        chk("glitch_no_output", n_rise, r0);
        en = 1'b0;
        send_frame(8'h66, 1'b1, 1'b0);
        idle(20);
        en = 1'b1;
        chk("en_low_no_output", n_rise, r0);

        // Framing error then recovery
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(20);
        chk("frame_err_count", n_ferr - f0, 1);
        chk("frame_err_no_output", n_rise, r0);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        idle(4);
        drain("drain_11");

        // Overrun with consumer stalled
        out_ready = 1'b0;
        o0 = n_ovr;
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h02, 1'b1, 1'b0);
        idle(10);
        chk("overrun_count", n_ovr - o0, 1);
        chk("overrun_hold_data", int'(out_data), 8'h01);
        chk("overrun_hold_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        idle(3);
        chk("consumed_valid_low", int'(out_valid), 0);
        drain("drain_01");

        // Reset mid-frame with a byte sitting in the buffer
        out_ready = 1'b0;
        send_frame(8'h33, 1'b1, 1'b0);
        idle(10);
        chk("pre_rst_valid", int'(out_valid), 1);
        idle(4);
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(1'b1);
        rx = 1'b1;
        idle(8);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_data", int'(out_data), 0);
        chk("midrst_errs", int'({frame_err, overrun, parity_err}), 0);
        idle(200);
        out_ready = 1'b1;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(4);
        drain("drain_5a");

`ifdef UART_RX_PARITY_EN
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(4);
        drain("drain_07");
        r0 = n_rise;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(10);
        chk("parity_err_count", n_perr, 1);
        chk("parity_no_output", n_rise, r0);
`else
        chk("parity_err_never", n_perr, 0);
`endif
        chk("total_frame_err", n_ferr, 1);
        chk("total_overrun", n_ovr, 1);
        drain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
